// File: rtl/usb_tx_serializer.sv
// usb_tx_serializer: USB full/low-speed transmit serializer.
// Sends SYNC, LSB-first payload bytes pulled through get_tx_data, then SE0/SE0/J EOP,
// NRZI-encoded onto D+/D-.
// Optional macro USB_TX_BIT_STUFF_EN: insert a 0 bit after six consecutive 1s.
module usb_tx_serializer #(
   parameter int unsigned CLKS_PER_BIT = 8
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       tx_start,
   input  logic [7:0] tx_packet_data,
   input  logic       tx_last,
   output logic       get_tx_data,
   output logic       dplus_out,
   output logic       dminus_out,
   output logic       tx_busy,
   output logic       tx_done
);

   localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_PRE = CW'(CLKS_PER_BIT - 2);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SYNC    = 3'd1,
      DATA    = 3'd2,
      EOP_SE0 = 3'd3,
      EOP_J   = 3'd4
   } state_t;

   state_t          r_state, w_state_nxt;
   logic [CW-1:0]   r_cnt, w_cnt_nxt;
   logic [2:0]      r_idx, w_idx_nxt;
   logic [7:0]      r_shift, w_shift_nxt;
   logic            r_last, w_last_nxt;
   logic            r_stuff, w_stuff_nxt;
   logic            r_dp, r_dm, r_busy, r_done, r_get;
   logic            w_line_nxt, w_se0_nxt, w_done_nxt, w_get_nxt, w_busy_nxt;
   logic            w_nb;
   logic            w_bit, w_bdry, w_ins_stuff, w_byte_end;

`ifdef USB_TX_BIT_STUFF_EN
   logic [2:0]      r_ones, w_ones_nxt;
   // A stuff bit follows the current bit when it is the sixth consecutive 1.
   assign w_ins_stuff = !r_stuff && w_bit && (r_ones == 3'd5);
`else
   assign w_ins_stuff = 1'b0;
`endif

   // Raw (pre-NRZI) value of the bit currently on the line.
   assign w_bit      = (r_state == SYNC) ? (r_idx == 3'd7) : r_shift[0];
   assign w_bdry     = (r_cnt == CNT_MAX);
   // Last bit time of a byte, counting a trailing stuff bit as part of it.
   assign w_byte_end = (r_idx == 3'd7) && (r_stuff || !w_ins_stuff);

   // Next-state, datapath and output decode.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_idx_nxt   = r_idx;
      w_shift_nxt = r_shift;
      w_last_nxt  = r_last;
      w_stuff_nxt = r_stuff;
      w_line_nxt  = r_dp;
      w_se0_nxt   = 1'b0;
      w_done_nxt  = 1'b0;
      w_get_nxt   = 1'b0;
      w_nb        = 1'b0;
`ifdef USB_TX_BIT_STUFF_EN
      w_ones_nxt  = r_ones;
`endif
      case (r_state)
         IDLE: begin
            w_line_nxt = 1'b1;
            w_cnt_nxt  = '0;
            if (tx_start) begin
               // First SYNC bit is a 0, so the line toggles from J to K.
               w_state_nxt = SYNC;
               w_idx_nxt   = '0;
               w_stuff_nxt = 1'b0;
               w_line_nxt  = 1'b0;
`ifdef USB_TX_BIT_STUFF_EN
               w_ones_nxt  = '0;
`endif
            end
         end
         SYNC, DATA: begin
            w_cnt_nxt = w_bdry ? '0 : r_cnt + CW'(1);
            w_get_nxt = (r_cnt == CNT_PRE) && w_byte_end && ((r_state == SYNC) || !r_last);
            if (w_bdry) begin
               if (w_ins_stuff) begin
                  w_stuff_nxt = 1'b1;
                  w_line_nxt  = ~r_dp;
`ifdef USB_TX_BIT_STUFF_EN
                  w_ones_nxt  = '0;
`endif
               end else begin
                  w_stuff_nxt = 1'b0;
`ifdef USB_TX_BIT_STUFF_EN
                  w_ones_nxt  = (r_stuff || !w_bit) ? 3'd0 : r_ones + 3'd1;
`endif
                  if (r_idx != 3'd7) begin
                     w_idx_nxt = r_idx + 3'd1;
                     if (r_state == DATA) begin
                        w_shift_nxt = {1'b0, r_shift[7:1]};
                        w_nb        = r_shift[1];
                     end else begin
                        w_nb        = (r_idx == 3'd6);
                     end
                     w_line_nxt = w_nb ? r_dp : ~r_dp;
                  end else if ((r_state == SYNC) || !r_last) begin
                     w_state_nxt = DATA;
                     w_idx_nxt   = '0;
                     w_shift_nxt = tx_packet_data;
                     w_last_nxt  = tx_last;
                     w_line_nxt  = tx_packet_data[0] ? r_dp : ~r_dp;
                  end else begin
                     w_state_nxt = EOP_SE0;
                     w_idx_nxt   = '0;
                     w_se0_nxt   = 1'b1;
                  end
               end
            end
         end
         EOP_SE0: begin
            w_cnt_nxt  = w_bdry ? '0 : r_cnt + CW'(1);
            w_line_nxt = 1'b1;
            w_se0_nxt  = 1'b1;
            if (w_bdry) begin
               if (r_idx == 3'd1) begin
                  w_state_nxt = EOP_J;
                  w_se0_nxt   = 1'b0;
               end else begin
                  w_idx_nxt = r_idx + 3'd1;
               end
            end
         end
         EOP_J: begin
            w_cnt_nxt  = w_bdry ? '0 : r_cnt + CW'(1);
            w_line_nxt = 1'b1;
            if (w_bdry) begin
               w_state_nxt = IDLE;
               w_done_nxt  = 1'b1;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_line_nxt  = 1'b1;
         end
      endcase
      w_busy_nxt = (w_state_nxt != IDLE);
   end

   // State, datapath and registered line/status outputs.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_shift <= '0;
         r_last  <= 1'b0;
         r_stuff <= 1'b0;
         r_dp    <= 1'b1;
         r_dm    <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_get   <= 1'b0;
`ifdef USB_TX_BIT_STUFF_EN
         r_ones  <= '0;
`endif
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_idx   <= w_idx_nxt;
         r_shift <= w_shift_nxt;
         r_last  <= w_last_nxt;
         r_stuff <= w_stuff_nxt;
         r_dp    <= w_line_nxt & ~w_se0_nxt;
         r_dm    <= ~w_line_nxt & ~w_se0_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
         r_get   <= w_get_nxt;
`ifdef USB_TX_BIT_STUFF_EN
         r_ones  <= w_ones_nxt;
`endif
      end
   end

   assign get_tx_data = r_get;
   assign dplus_out   = r_dp;
   assign dminus_out  = r_dm;
   assign tx_busy     = r_busy;
   assign tx_done     = r_done;

endmodule

// File: doc/usb_tx_serializer.md
USB_TX_SERIALIZER -- requirements
Module: usb_tx_serializer

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 8, meaning clock cycles per USB bit time (legal 4..16).
REQ-002 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-003 SHALL have port n_rst  input  1  asynchronous active-low reset.
REQ-004 SHALL have port tx_start  input  1  single-cycle request to begin a packet; honoured only in IDLE.
REQ-005 SHALL have port tx_packet_data  input  8  next payload byte, transmitted LSB first.
REQ-006 SHALL have port tx_last  input  1  marks tx_packet_data as the final byte; sampled with it.
REQ-007 SHALL have port get_tx_data  output  1  one-cycle pulse: tx_packet_data/tx_last are captured at the end of this cycle.
REQ-008 SHALL have port dplus_out  output  1  D+ line drive.
REQ-009 SHALL have port dminus_out  output  1  D- line drive.
REQ-010 SHALL have port tx_busy  output  1  high while a packet is in progress.
REQ-011 SHALL have port tx_done  output  1  one-cycle pulse at packet completion.

Function
REQ-012 SHALL implement states IDLE, SYNC, DATA, EOP_SE0, EOP_J; transitions: IDLE->SYNC on tx_start; SYNC->DATA after 8 bits; DATA->EOP_SE0 after the last bit of the tx_last byte (including any pending stuff bit); EOP_SE0->EOP_J after 2 bit times; EOP_J->IDLE after 1 bit time.
REQ-013 SHALL use a bit-time counter 0..CLKS_PER_BIT-1; a bit boundary occurs when the counter equals CLKS_PER_BIT-1; the counter is cleared on entry to SYNC.
REQ-014 SHALL drive the first SYNC bit in the cycle after tx_start is sampled; each bit holds exactly CLKS_PER_BIT cycles.
REQ-015 SYNC SHALL transmit byte 8'h80 LSB first (seven 0s, then one 1).
REQ-016 SHALL NRZI-encode SYNC/DATA bits: a 0 toggles the line state, a 1 holds it; J = (D+=1, D-=0), K = (D+=0, D-=1); the state entering SYNC is J.
REQ-017 SHALL pulse get_tx_data at the last cycle of the final SYNC bit and at the last cycle of bit 7 of every non-last DATA byte; the captured byte's bit 0 starts on the next cycle.
REQ-018 SHALL NOT pulse get_tx_data after a byte captured with tx_last=1.
REQ-019 EOP_SE0 SHALL drive D+=0, D-=0; EOP_J and IDLE SHALL drive J.
REQ-020 tx_busy SHALL be high from the first SYNC cycle through the last EOP_J cycle, inclusive.
REQ-021 tx_done SHALL pulse high in the first IDLE cycle after EOP_J.
REQ-022 tx_start SHALL be ignored while tx_busy is high; tx_start in the tx_done cycle SHALL be accepted.

Reset
REQ-023 n_rst low SHALL immediately force IDLE, D+=1, D-=0, tx_busy=0, tx_done=0, get_tx_data=0, counters and shift register cleared, regardless of state (mid-packet abort, no EOP).

Configuration
REQ-024 Macro USB_TX_BIT_STUFF_EN SHALL select bit stuffing: when defined, a ones counter counts consecutive transmitted 1s (SYNC included); on reaching 6 it inserts one 0 bit (NRZI toggle, full bit time), then clears; any 0 bit clears it; get_tx_data timing stretches by the stuff bit; a stuff bit due after the final data bit is sent before EOP.
REQ-025 When USB_TX_BIT_STUFF_EN is undefined, no stuff bits SHALL be inserted and the ones counter SHALL not exist.

Verification
REQ-026 Reset mid-DATA -> same cycle lines J, tx_busy=0; next tx_start yields a normal SYNC.
REQ-027 tx_start, byte 8'hA5 tx_last=1, CLKS_PER_BIT=8 -> line K J K J K J K K | K J J K J J K K | SE0 SE0 J; tx_busy 152 cycles; tx_done pulse; get_tx_data pulsed once.
REQ-028 Byte 8'hFF tx_last=1, macro defined -> after SYNC: K x5, stuff J, J x3, then EOP; 17 bit times before SE0.
REQ-029 Same as REQ-028 with macro undefined -> 8 held K bits after SYNC; 16 bit times before SE0.
REQ-030 Three bytes 8'h01, 8'h02, 8'h03 (last on third) -> exactly 3 get_tx_data pulses, spaced 64 cycles, bytes emitted in order LSB first.
REQ-031 tx_start asserted during DATA and again in tx_done cycle -> first ignored, second starts SYNC on the next cycle.
